// File: rtl/mfp_adc_seq_pkg.sv
// Shared constants for the MAX10 ADC slot sequencer.
// Register map offsets, mode encodings and FSM state type.
package mfp_adc_seq_pkg;

  localparam int REG_CONTROL = 0;
  localparam int REG_STATUS  = 1;
  localparam int REG_MASK    = 2;
  localparam int REG_START   = 3;
  localparam int REG_SLOT0   = 16;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_CONT   = 2'd1,
    MODE_TRIG   = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RESP,
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/mfp_adc_seq_avg.sv
// Per-slot sample accumulator: 2^LOG2 conversions summed, result = sum>>LOG2.
// LOG2=0 degenerates to a single pass-through conversion.
module mfp_adc_seq_avg
  import mfp_adc_seq_pkg::*;
#(
  parameter int LOG2 = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        sample_valid_i,
  input  logic [11:0] sample_i,
  output logic        first_o,
  output logic        last_o,
  output logic        done_o,
  output logic [11:0] result_o
);

  localparam int CW = (LOG2 > 0) ? LOG2 : 1;
  localparam int AW = 12 + LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2) - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d, sum;

  always_comb begin
    sum      = acc_q + AW'(sample_i);
    first_o  = (cnt_q == '0);
    last_o   = (cnt_q == CNT_LAST);
    done_o   = sample_valid_i & last_o;
    result_o = 12'(sum >> LOG2);
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (sample_valid_i) begin
      if (last_o) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mfp_adc_max10_seq.sv
// MAX10 ADC slot sequencer with register port and command/response streams.
// Define MFP_ADC_SEQ_AVG_EN to average 2^AVG_LOG2 conversions per slot.
module mfp_adc_max10_seq
  import mfp_adc_seq_pkg::*;
#(
  parameter int SLOT_COUNT = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AVG_LOG2   = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_data,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [31:0]           write_data,
  input  logic                  write_enable,
  output logic                  ADC_C_Valid,
  output logic [4:0]            ADC_C_Channel,
  output logic                  ADC_C_SOP,
  output logic                  ADC_C_EOP,
  input  logic                  ADC_C_Ready,
  input  logic                  ADC_R_Valid,
  input  logic [4:0]            ADC_R_Channel,
  input  logic [11:0]           ADC_R_Data,
  input  logic                  ADC_R_SOP,
  input  logic                  ADC_R_EOP,
  input  logic                  ADC_Trigger,
  output logic                  ADC_Interrupt
);

`ifdef MFP_ADC_SEQ_AVG_EN
  localparam int AL = AVG_LOG2;
`else
  localparam int AL = 0 * AVG_LOG2;
`endif
  localparam int SW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

  state_e                state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic                  en_q, irq_en_q, done_q, ovr_q, trig_q;
  logic [1:0]            mode_q;
  logic [SLOT_COUNT-1:0] mask_q, vld_q;
  logic [4:0]            chan_q [SLOT_COUNT];
  logic [11:0]           res_q  [SLOT_COUNT];

  logic [SW-1:0] first_idx, next_idx;
  logic          has_next, start_wr, trig_rise, go, launch;
  logic          set_done, set_ovr, latch;
  logic          avg_first, avg_last, avg_done;
  logic [11:0]   avg_res;
  int            wa, ra;
  logic          unused_w;

  assign wa = int'(write_addr);
  assign ra = int'(read_addr);
  assign unused_w = ^{write_data, ADC_R_Channel, ADC_R_SOP, ADC_R_EOP};

  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_idx = SW'(i);
        if (i > int'(slot_q)) begin
          next_idx = SW'(i);
          has_next = 1'b1;
        end
      end
    end
  end

  assign start_wr  = write_enable && (wa == REG_START);
  assign trig_rise = ADC_Trigger & ~trig_q;
  assign go = (mode_q == MODE_TRIG) ? trig_rise :
              ((mode_q == MODE_SINGLE) || (mode_q == MODE_CONT)) & start_wr;
  assign launch  = go & en_q & (|mask_q);
  assign set_ovr = go & (state_q != S_IDLE);
  assign ADC_Interrupt = irq_en_q & (done_q | ovr_q);

  mfp_adc_seq_avg #(.LOG2(AL)) u_avg (
    .clk_i          (CLK),
    .rst_i          (RESET),
    .clear_i        (state_q == S_IDLE),
    .sample_valid_i ((state_q == S_RESP) && ADC_R_Valid),
    .sample_i       (ADC_R_Data),
    .first_o        (avg_first),
    .last_o         (avg_last),
    .done_o         (avg_done),
    .result_o       (avg_res)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    ADC_C_Valid   = 1'b0;
    ADC_C_Channel = '0;
    ADC_C_SOP     = 1'b0;
    ADC_C_EOP     = 1'b0;
    latch         = 1'b0;
    set_done      = 1'b0;
    unique case (state_q)
      S_IDLE: if (launch) begin
        state_d = S_CMD;
        slot_d  = first_idx;
      end
      S_CMD: begin
        ADC_C_Valid   = 1'b1;
        ADC_C_Channel = chan_q[slot_q];
        ADC_C_SOP     = (slot_q == first_idx) & avg_first;
        ADC_C_EOP     = ~has_next & avg_last;
        if (ADC_C_Ready) state_d = S_RESP;
      end
      S_RESP: if (ADC_R_Valid) begin
        latch = avg_done;
        // a disable only takes effect once the outstanding response is in
        if (!en_q)         state_d = S_IDLE;
        else if (avg_done) state_d = S_NEXT;
        else               state_d = S_CMD;
      end
      S_NEXT: begin
        if (!en_q) state_d = S_IDLE;
        else if (has_next) begin
          state_d = S_CMD;
          slot_d  = next_idx;
        end else state_d = S_DONE;
      end
      S_DONE: begin
        set_done = 1'b1;
        if (en_q && (mode_q == MODE_CONT) && (|mask_q)) begin
          state_d = S_CMD;
          slot_d  = first_idx;
        end else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      trig_q  <= ADC_Trigger;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en_q     <= 1'b0;
      mode_q   <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      mask_q   <= '0;
      vld_q    <= '0;
      for (int i = 0; i < SLOT_COUNT; i++) begin
        chan_q[i] <= '0;
        res_q[i]  <= '0;
      end
    end else begin
      if (write_enable) begin
        if (wa == REG_CONTROL) begin
          en_q     <= write_data[0];
          mode_q   <= write_data[2:1];
          irq_en_q <= write_data[3];
        end
        if (wa == REG_STATUS) begin
          if (write_data[1]) done_q <= 1'b0;
          if (write_data[2]) ovr_q  <= 1'b0;
        end
        if (wa == REG_MASK) mask_q <= write_data[SLOT_COUNT-1:0];
        for (int i = 0; i < SLOT_COUNT; i++)
          if (wa == REG_SLOT0 + i) chan_q[i] <= write_data[4:0];
      end
      // set events come last so they beat a same-cycle clear
      if (set_done) done_q <= 1'b1;
      if (set_ovr)  ovr_q  <= 1'b1;
      if (latch) begin
        res_q[slot_q] <= avg_res;
        vld_q[slot_q] <= 1'b1;
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (ra == REG_CONTROL)
      read_data = {28'b0, irq_en_q, mode_q, en_q};
    else if (ra == REG_STATUS)
      read_data = {29'b0, ovr_q, done_q, state_q != S_IDLE};
    else if (ra == REG_MASK)
      read_data = 32'(mask_q);
    for (int i = 0; i < SLOT_COUNT; i++)
      if (ra == REG_SLOT0 + i) read_data = {vld_q[i], 19'b0, res_q[i]};
  end

endmodule

// File: tb/tb_mfp_adc_max10_seq.sv
// Directed bench for mfp_adc_max10_seq with an auto-responding ADC model.
// Expected values are hand-computed from the register map and stream rules.
module tb_mfp_adc_max10_seq;

`ifdef MFP_ADC_SEQ_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  read_addr, write_addr;
  logic [31:0] read_data, write_data;
  logic        write_enable;
  logic        ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Ready;
  logic [4:0]  ADC_C_Channel, ADC_R_Channel;
  logic        ADC_R_Valid, ADC_R_SOP, ADC_R_EOP;
  logic [11:0] ADC_R_Data;
  logic        ADC_Trigger, ADC_Interrupt;

  int total = 0;
  int bad = 0;
  logic [6:0] cmd_log[$];
  bit   pending = 0;
  bit   auto_resp = 1;
  bit   avg_mode = 0;
  int   avg_k = 0;
  logic [4:0] pch;
  logic [31:0] v;

  mfp_adc_max10_seq dut (
    .CLK(CLK), .RESET(RESET),
    .read_addr(read_addr), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data),
    .write_enable(write_enable),
    .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel),
    .ADC_C_SOP(ADC_C_SOP), .ADC_C_EOP(ADC_C_EOP),
    .ADC_C_Ready(ADC_C_Ready),
    .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel),
    .ADC_R_Data(ADC_R_Data), .ADC_R_SOP(ADC_R_SOP),
    .ADC_R_EOP(ADC_R_EOP),
    .ADC_Trigger(ADC_Trigger), .ADC_Interrupt(ADC_Interrupt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge CLK);
    write_addr = 5'(a);
    write_data = d;
    write_enable = 1'b1;
    @(negedge CLK);
    write_enable = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    @(negedge CLK);
    read_addr = 5'(a);
    #1 d = read_data;
  endtask

  task automatic wait_idle(input string tag, input int max);
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < max; i++) begin
      rd(1, s);
      if (!s[0]) break;
    end
    chk(tag, 32'(s[0]), 0);
  endtask

  // ADC model: answer each accepted command one cycle later
  initial begin
    ADC_R_Valid = 0;
    ADC_R_Data = '0;
    ADC_R_Channel = '0;
    ADC_R_SOP = 0;
    ADC_R_EOP = 0;
    forever begin
      @(negedge CLK);
      ADC_R_Valid = 1'b0;
      if (pending && auto_resp) begin
        ADC_R_Valid = 1'b1;
        ADC_R_Channel = pch;
        if (avg_mode) begin
          ADC_R_Data = 12'(100 + 2 * avg_k);
          avg_k++;
        end else ADC_R_Data = 12'h100 + {3'b0, pch, 4'b0};
        pending = 0;
      end
      if (ADC_C_Valid && ADC_C_Ready) begin
        cmd_log.push_back({ADC_C_SOP, ADC_C_EOP, ADC_C_Channel});
        pch = ADC_C_Channel;
        pending = 1;
      end
    end
  end

  initial begin
    bit sv, sb;
    RESET = 1;
    read_addr = '0;
    write_addr = '0;
    write_data = '0;
    write_enable = 0;
    ADC_C_Ready = 1;
    ADC_Trigger = 0;
    repeat (3) @(negedge CLK);
    RESET = 0;

    rd(0, v); chk("rst_ctrl", v, 0);
    rd(1, v); chk("rst_status", v, 0);
    rd(2, v); chk("rst_mask", v, 0);
    rd(16, v); chk("rst_slot0", v, 0);
    chk("rst_cvalid", 32'(ADC_C_Valid), 0);
    chk("rst_irq", 32'(ADC_Interrupt), 0);

    // two-slot single sequence
    wr(16, 3);
    wr(18, 7);
    wr(2, 5);
    wr(0, 9);
    rd(0, v); chk("ctrl_rb", v, 9);
    wr(3, 0);
    wait_idle("seq_busy", 60);
    chk("seq_ncmd", cmd_log.size(), 2 * NS);
    chk("seq_cmd0", 32'(cmd_log[0]), 32'h43);
    chk("seq_cmdN", 32'(cmd_log[2*NS-1]), 32'h27);
    rd(16, v); chk("seq_slot0", v, 32'h8000_0130);
    rd(17, v); chk("seq_slot1", v, 0);
    rd(18, v); chk("seq_slot2", v, 32'h8000_0170);
    rd(1, v); chk("seq_status", v, 2);
    chk("seq_irq", 32'(ADC_Interrupt), 1);
    wr(1, 2);
    rd(1, v); chk("seq_clr", v, 0);
    chk("seq_irq_clr", 32'(ADC_Interrupt), 0);

    // empty mask: start is a no-op
    cmd_log.delete();
    wr(0, 1);
    wr(2, 0);
    wr(3, 0);
    sv = 0;
    sb = 0;
    for (int i = 0; i < 10; i++) begin
      rd(1, v);
      if (ADC_C_Valid) sv = 1;
      if (v[0]) sb = 1;
    end
    chk("m0_valid", 32'(sv), 0);
    chk("m0_busy", 32'(sb), 0);
    chk("m0_ncmd", cmd_log.size(), 0);

    // triggered, re-trigger while busy collides with overrun clear
    cmd_log.delete();
    wr(2, 5);
    wr(0, 32'hD);
    @(negedge CLK); ADC_Trigger = 1;
    @(negedge CLK); ADC_Trigger = 0;
    @(negedge CLK);
    ADC_Trigger = 1;
    write_addr = 5'd1;
    write_data = 32'h4;
    write_enable = 1;
    @(negedge CLK);
    write_enable = 0;
    wait_idle("trg_busy", 60);
    chk("trg_ncmd", cmd_log.size(), 2 * NS);
    rd(1, v); chk("trg_status", v, 6);
    chk("trg_irq", 32'(ADC_Interrupt), 1);
    wr(1, 4);
    rd(1, v); chk("trg_clr_ovr", v, 2);
    wr(1, 2);
    ADC_Trigger = 0;
    rd(1, v); chk("trg_clr_done", v, 0);

    // continuous, disable while waiting for the response
    cmd_log.delete();
    wr(16, 5);
    wr(2, 1);
    auto_resp = 0;
    wr(0, 3);
    wr(3, 0);
    for (int i = 0; i < 20 && cmd_log.size() == 0; i++) @(negedge CLK);
    chk("cont_cmd_seen", cmd_log.size(), 1);
    wr(0, 2);
    auto_resp = 1;
    wait_idle("cont_busy", 30);
    chk("cont_ncmd", cmd_log.size(), 1);
    rd(16, v);
    chk("cont_slot0", v, (NS == 1) ? 32'h8000_0150 : 32'h8000_0130);
    rd(1, v); chk("cont_status", v, 0);

    // reset while a command is being offered
    ADC_C_Ready = 0;
    wr(2, 5);
    wr(0, 1);
    wr(3, 0);
    for (int i = 0; i < 10 && !ADC_C_Valid; i++) @(negedge CLK);
    chk("mid_valid", 32'(ADC_C_Valid), 1);
    RESET = 1;
    #1;
    chk("mid_rst_valid", 32'(ADC_C_Valid), 0);
    chk("mid_rst_chan", 32'(ADC_C_Channel), 0);
    chk("mid_rst_sop", 32'(ADC_C_SOP), 0);
    @(negedge CLK);
    RESET = 0;
    ADC_C_Ready = 1;
    pending = 0;
    rd(16, v); chk("mid_slot0", v, 0);
    rd(18, v); chk("mid_slot2", v, 0);
    rd(0, v); chk("mid_ctrl", v, 0);

`ifdef MFP_ADC_SEQ_AVG_EN
    cmd_log.delete();
    avg_mode = 1;
    avg_k = 0;
    wr(17, 1);
    wr(2, 2);
    wr(0, 1);
    wr(3, 0);
    wait_idle("avg_busy", 60);
    rd(17, v); chk("avg_slot1", v, 32'h8000_0067);
    chk("avg_ncmd", cmd_log.size(), 4);
    chk("avg_cmd0", 32'(cmd_log[0]), 32'h41);
    chk("avg_cmd3", 32'(cmd_log[3]), 32'h21);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
